memory_io: RTL and testbench

//  Memory and I/O stage directly downstream of the cpu bus interface (addr_bus/bus/c_ri/c_ro/mem_clk).
//  256x8 RAM plus three memory-mapped locations: an output port backed by a FIFO,
//  a single-byte input port, and a read-only status byte.

---
 rtl/memory_io.sv | 169 ++++++++++++++++
 tb/tb_memory_io.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_io.sv
// ---------------------------------------------------------------------------
// memory_io
// Memory and I/O stage that sits on the cpu bus. It holds a 256x8 RAM and
// three memory-mapped locations:
//   OUT_ADDR  : write-only output port; a cpu write pushes into an output FIFO
//   IN_ADDR   : read-only input port; a cpu read pops a one-byte holding reg
//   STAT_ADDR : read-only status {5'b0, in_full, out_empty, out_full}
// RAM contents are not initialised and are never cleared by reset.
//
// Ports
//   clk        system clock (same clock as the cpu)
//   reset      asynchronous, active-low reset
//   addr_bus   address from the cpu MAR
//   c_ri       cpu write strobe (memory captures bus)
//   c_ro       cpu read strobe (memory drives bus)
//   mem_clk    cpu memory phase; commits happen on its rising edge
//   bus        shared 8-bit data bus, driven only while c_ro=1
//   out_data   head of the output FIFO (meaningful while out_valid=1)
//   out_valid  output FIFO not empty
//   out_ready  consumer accepts out_data on a clk edge with out_valid
//   in_data    byte offered by the host
//   in_valid   host offers in_data
//   in_ready   input holding register empty
// ---------------------------------------------------------------------------
module memory_io #(
    parameter logic [7:0] OUT_ADDR   = 8'hF0,
    parameter logic [7:0] IN_ADDR    = 8'hF1,
    parameter logic [7:0] STAT_ADDR  = 8'hF2,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr_bus,
    input  logic       c_ri,
    input  logic       c_ro,
    input  logic       mem_clk,
    inout  wire  [7:0] bus,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {IN_EMPTY, IN_FULL} in_state_t;

    logic [7:0]    ram_q [256];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_seen_q, ovf_seen_d;
    logic          mem_clk_q;
    in_state_t     state_q, state_d;
    logic [7:0]    in_reg_q, in_reg_d;

    logic       mem_edge;
    logic       wr_commit;
    logic       push_req, push, pop, cpu_pop;
    logic       ram_we;
    logic       out_full, out_empty, in_full;
    logic [7:0] rdata;

    // A commit fires once per mem_clk rising edge regardless of how long the
    // strobes stay high. Gating with reset keeps a mid-transfer reset from
    // writing RAM, which has no reset of its own.
    assign mem_edge  = mem_clk & ~mem_clk_q;
    assign wr_commit = mem_edge & c_ri & reset;
    assign cpu_pop   = mem_edge & c_ro & reset & (addr_bus == IN_ADDR);

    assign ram_we   = wr_commit && (addr_bus != OUT_ADDR) &&
                      (addr_bus != IN_ADDR) && (addr_bus != STAT_ADDR);
    assign push_req = wr_commit && (addr_bus == OUT_ADDR);

    assign out_empty = (wr_ptr_q == rd_ptr_q);
    assign out_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign out_valid = ~out_empty;
    assign out_data  = fifo_q[rd_ptr_q[AW-1:0]];

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign pop  = out_valid & out_ready;
    assign push = push_req & (~out_full | pop);

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ovf_seen_d = ovf_seen_q | (push_req & ~push);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_seen_q <= 1'b0;
            mem_clk_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_seen_q <= ovf_seen_d;
            mem_clk_q  <= mem_clk;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= bus;
        end
        if (ram_we) begin
            ram_q[addr_bus] <= bus;
        end
    end

    // Input holding register: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IN_EMPTY;
            in_reg_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            in_reg_q <= in_reg_d;
        end
    end

    // Input holding register: next state. A pop while EMPTY changes nothing.
    always_comb begin
        state_d  = state_q;
        in_reg_d = in_reg_q;
        case (state_q)
            IN_EMPTY: begin
                if (in_valid) begin
                    state_d  = IN_FULL;
                    in_reg_d = in_data;
                end
            end
            IN_FULL: begin
                if (cpu_pop) begin
                    state_d = IN_EMPTY;
                end
            end
            default: state_d = IN_EMPTY;
        endcase
    end

    // Input holding register: outputs
    always_comb begin
        in_ready = (state_q == IN_EMPTY);
        in_full  = (state_q == IN_FULL);
    end

    always_comb begin
        if (addr_bus == IN_ADDR) begin
            rdata = in_full ? in_reg_q : 8'h00;
        end else if (addr_bus == STAT_ADDR) begin
            rdata = {5'b0, in_full, out_empty, out_full};
        end else if (addr_bus == OUT_ADDR) begin
            rdata = 8'h00;
        end else begin
            rdata = ram_q[addr_bus];
        end
    end

    assign bus = c_ro ? rdata : 8'bz;

endmodule

// File: tb/tb_memory_io.sv
// ---------------------------------------------------------------------------
// tb_memory_io
// Directed bench for memory_io: reset state, RAM access, single commit per
// mem_clk pulse, output FIFO fill/overflow/drain, full push+pop, input port
// handshake, and reset in the middle of activity.
// ---------------------------------------------------------------------------
module tb_memory_io;

    logic       clk;
    logic       reset;
    logic [7:0] addrBus;
    logic       cRi;
    logic       cRo;
    logic       memClk;
    wire  [7:0] bus;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic [7:0] inData;
    logic       inValid;
    logic       inReady;

    logic [7:0] busDrive;
    logic       busDriveEn;

    int checks;
    int errors;

    assign bus = busDriveEn ? busDrive : 8'bz;

    memory_io dut (
        .clk       (clk),
        .reset     (reset),
        .addr_bus  (addrBus),
        .c_ri      (cRi),
        .c_ro      (cRo),
        .mem_clk   (memClk),
        .bus       (bus),
        .out_data  (outData),
        .out_valid (outValid),
        .out_ready (outReady),
        .in_data   (inData),
        .in_valid  (inValid),
        .in_ready  (inReady)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cpu write: strobes and mem_clk high across one clk edge, then a
    // low cycle so the next write sees a fresh mem_clk rising edge.
    task automatic cpuWrite(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addrBus    = a;
        busDrive   = d;
        busDriveEn = 1'b1;
        cRi        = 1'b1;
        memClk     = 1'b1;
        @(negedge clk);
        cRi        = 1'b0;
        memClk     = 1'b0;
        busDriveEn = 1'b0;
        @(negedge clk);
    endtask

    // Combinational read with mem_clk low, so nothing is committed
    task automatic readBus(input logic [7:0] a, output logic [7:0] d);
        addrBus = a;
        cRo     = 1'b1;
        #1;
        d       = bus;
        cRo     = 1'b0;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        @(negedge clk);
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got %b expected 0", outValid);
        end
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b expected 1", inReady);
        end
        checks++;
        if (dut.ovf_seen_q !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ovf got %b expected 0", dut.ovf_seen_q);
        end
        // The bench drives 00; any DUT drive of status (02) would show up
        addrBus    = 8'hF2;
        busDrive   = 8'h00;
        busDriveEn = 1'b1;
        #1;
        checks++;
        if (bus !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_bus_z got %h expected 00", bus);
        end
        busDriveEn = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        readBus(8'hF2, d);
        checks++;
        if (d !== 8'h02) begin
            errors++;
            $display("[TB] FAIL reset_status got %h expected 02", d);
        end
    endtask

    task automatic test_ram();
        logic [7:0] d;
        cpuWrite(8'h10, 8'hA5);
        cpuWrite(8'hFF, 8'h5A);
        cpuWrite(8'h00, 8'hC3);
        cpuWrite(8'hF2, 8'hFF);
        readBus(8'h10, d);
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL ram_10 got %h expected a5", d);
        end
        readBus(8'hFF, d);
        checks++;
        if (d !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL ram_ff got %h expected 5a", d);
        end
        readBus(8'h00, d);
        checks++;
        if (d !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL ram_00 got %h expected c3", d);
        end
        readBus(8'hF2, d);
        checks++;
        if (d !== 8'h02) begin
            errors++;
            $display("[TB] FAIL stat_write_ignored got %h expected 02", d);
        end
    endtask

    task automatic test_single_commit();
        logic [7:0] d;
        @(negedge clk);
        addrBus    = 8'hF0;
        busDrive   = 8'h9E;
        busDriveEn = 1'b1;
        cRi        = 1'b1;
        memClk     = 1'b1;
        repeat (3) @(negedge clk);
        memClk     = 1'b0;
        cRi        = 1'b0;
        busDriveEn = 1'b0;
        @(negedge clk);
        checks++;
        if (outValid !== 1'b1 || outData !== 8'h9E) begin
            errors++;
            $display("[TB] FAIL single_commit_head got %b/%h expected 1/9e", outValid, outData);
        end
        readBus(8'hF2, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("[TB] FAIL single_commit_status got %h expected 00", d);
        end
        @(negedge clk);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_commit_count got %b expected 0", outValid);
        end
    endtask

    task automatic test_fifo();
        logic [7:0] d;
        logic [7:0] expData [4];
        expData[0] = 8'h01;
        expData[1] = 8'h02;
        expData[2] = 8'h03;
        expData[3] = 8'h04;
        outReady = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cpuWrite(8'hF0, 8'(i));
        end
        readBus(8'hF2, d);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("[TB] FAIL fifo_full_status got %h expected 01", d);
        end
        checks++;
        if (dut.ovf_seen_q !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fifo_ovf got %b expected 1", dut.ovf_seen_q);
        end
        @(negedge clk);
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outValid !== 1'b1 || outData !== expData[i]) begin
                errors++;
                $display("[TB] FAIL fifo_drain_%0d got %b/%h expected 1/%h", i, outValid, outData, expData[i]);
            end
            @(negedge clk);
        end
        outReady = 1'b0;
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fifo_empty got %b expected 0", outValid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d;
        logic [7:0] expData [4];
        expData[0] = 8'h22;
        expData[1] = 8'h33;
        expData[2] = 8'h44;
        expData[3] = 8'h55;
        doReset();
        outReady = 1'b0;
        cpuWrite(8'hF0, 8'h11);
        cpuWrite(8'hF0, 8'h22);
        cpuWrite(8'hF0, 8'h33);
        cpuWrite(8'hF0, 8'h44);
        readBus(8'hF2, d);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("[TB] FAIL pushpop_pre_status got %h expected 01", d);
        end
        @(negedge clk);
        outReady   = 1'b1;
        addrBus    = 8'hF0;
        busDrive   = 8'h55;
        busDriveEn = 1'b1;
        cRi        = 1'b1;
        memClk     = 1'b1;
        @(negedge clk);
        outReady   = 1'b0;
        cRi        = 1'b0;
        memClk     = 1'b0;
        busDriveEn = 1'b0;
        checks++;
        if (outValid !== 1'b1 || outData !== 8'h22) begin
            errors++;
            $display("[TB] FAIL pushpop_head got %b/%h expected 1/22", outValid, outData);
        end
        readBus(8'hF2, d);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("[TB] FAIL pushpop_still_full got %h expected 01", d);
        end
        checks++;
        if (dut.ovf_seen_q !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pushpop_no_ovf got %b expected 0", dut.ovf_seen_q);
        end
        @(negedge clk);
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outValid !== 1'b1 || outData !== expData[i]) begin
                errors++;
                $display("[TB] FAIL pushpop_drain_%0d got %b/%h expected 1/%h", i, outValid, outData, expData[i]);
            end
            @(negedge clk);
        end
        outReady = 1'b0;
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pushpop_empty got %b expected 0", outValid);
        end
    endtask

    task automatic test_input();
        logic [7:0] d;
        @(negedge clk);
        inData  = 8'h3C;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        inData  = 8'h00;
        checks++;
        if (inReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL input_captured got %b expected 0", inReady);
        end
        readBus(8'hF2, d);
        checks++;
        if (d !== 8'h06) begin
            errors++;
            $display("[TB] FAIL input_status got %h expected 06", d);
        end
        @(negedge clk);
        addrBus = 8'hF1;
        cRo     = 1'b1;
        memClk  = 1'b1;
        #1;
        checks++;
        if (bus !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL input_read got %h expected 3c", bus);
        end
        @(negedge clk);
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL input_popped got %b expected 1", inReady);
        end
        memClk = 1'b0;
        cRo    = 1'b0;
        @(negedge clk);
        readBus(8'hF1, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("[TB] FAIL input_second_read got %h expected 00", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        outReady = 1'b0;
        cpuWrite(8'hF0, 8'hA1);
        cpuWrite(8'hF0, 8'hB2);
        inData  = 8'h77;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        checks++;
        if (outValid !== 1'b1 || inReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_pre got valid %b ready %b expected 1 0", outValid, inReady);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_out_valid got %b expected 0", outValid);
        end
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_in_ready got %b expected 1", inReady);
        end
        addrBus    = 8'hF1;
        busDrive   = 8'h00;
        busDriveEn = 1'b1;
        #1;
        checks++;
        if (bus !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mid_bus_z got %h expected 00", bus);
        end
        busDriveEn = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        readBus(8'h10, d);
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL mid_ram_kept got %h expected a5", d);
        end
        readBus(8'hF2, d);
        checks++;
        if (d !== 8'h02) begin
            errors++;
            $display("[TB] FAIL mid_status got %h expected 02", d);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        addrBus    = 8'h00;
        cRi        = 1'b0;
        cRo        = 1'b0;
        memClk     = 1'b0;
        outReady   = 1'b0;
        inData     = 8'h00;
        inValid    = 1'b0;
        busDrive   = 8'h00;
        busDriveEn = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] starting directed tests");
        test_reset();
        test_ram();
        test_single_commit();
        test_fifo();
        test_full_push_pop();
        test_input();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
